// File: rtl/irq_accept.sv
// irq_accept: CPU-side interrupt acceptor for the 8080-style core.
// Turns toggles on the controller's irq line into queued 4-bit vectors, owns
// the iff1 interrupt-enable flag and runs the RST-style entry sequence at an
// opcode-fetch boundary: push PC high, push PC low, then jump to vect*8.
// Optional feature macro: IRQ_ACCEPT_NMI_EN adds a rising-edge nmi input that
// enters at 0x0066 regardless of iff1 and without touching the vector FIFO.
module irq_accept #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        irq,
    input  logic [3:0]  vect,
    input  logic        ei,
    input  logic        di,
    input  logic        boundary,
    input  logic [15:0] pc,
    input  logic [15:0] sp,
    input  logic        mem_ready,
`ifdef IRQ_ACCEPT_NMI_EN
    input  logic        nmi,
`endif
    output logic        iff1,
    output logic        take,
    output logic        busy,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_out,
    output logic        pc_load,
    output logic [15:0] new_pc,
    output logic        sp_load,
    output logic [15:0] new_sp,
    output logic        ovf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [15:0] NMI_VECTOR = 16'h0066;

    typedef enum logic [1:0] {
        IDLE,
        PUSH_HI,
        PUSH_LO,
        JUMP
    } state_t;

    state_t            state_q;

    // Request detection and vector queue.
    logic              irqPrev_q;
    logic [3:0]        fifoMem_q [DEPTH];
    logic [PTR_W-1:0]  rdPtr_q;
    logic [PTR_W-1:0]  wrPtr_q;
    logic [PTR_W:0]    count_q;
    logic              ovf_q;

    // Interrupt enable and the latched vector being serviced.
    logic              iff1_q;
    logic [3:0]        vecR_q;
    logic              vecNmi_q;

    // Registered outputs of the entry sequence.
    logic              memWe_q;
    logic [15:0]       memAddr_q;
    logic [7:0]        memOut_q;
    logic              pcLoad_q;
    logic [15:0]       newPc_q;
    logic              spLoad_q;
    logic [15:0]       newSp_q;

    logic              pushReq;
    logic              fifoEmpty;
    logic              fifoFull;
    logic              fifoPop;
    logic              fifoWrite;
    logic              fifoDrop;
    logic [3:0]        fifoHead;
    logic              normalAccept;
    logic              nmiAccept;
    logic              accept;
    logic [15:0]       spMinus1;
    logic [15:0]       spMinus2;

    assign pushReq      = irq ^ irqPrev_q;
    assign fifoEmpty    = (count_q == '0);
    assign fifoFull     = (count_q == FULL_COUNT);
    assign fifoHead     = fifoMem_q[rdPtr_q];
    assign normalAccept = (state_q == IDLE) && !fifoEmpty && iff1_q && boundary;

`ifdef IRQ_ACCEPT_NMI_EN
    logic nmiPrev_q;
    logic nmiPend_q;
    logic nmiRise;

    assign nmiRise   = nmi & ~nmiPrev_q;
    assign nmiAccept = nmiPend_q && (state_q == IDLE) && boundary;

    // Rising-edge detect on nmi; a fresh edge in the accept cycle stays pending.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            nmiPrev_q <= 1'b0;
            nmiPend_q <= 1'b0;
        end else begin
            nmiPrev_q <= nmi;
            nmiPend_q <= (nmiPend_q & ~nmiAccept) | nmiRise;
        end
    end
`else
    assign nmiAccept = 1'b0;
`endif

    // An NMI entry takes priority and leaves the vector queue untouched.
    assign accept    = nmiAccept || normalAccept;
    assign fifoPop   = normalAccept && !nmiAccept;
    assign fifoWrite = pushReq && (!fifoFull || fifoPop);
    assign fifoDrop  = pushReq && fifoFull && !fifoPop;

    assign spMinus1  = sp - 16'd1;
    assign spMinus2  = sp - 16'd2;

    // Vector storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clock) begin
        if (fifoWrite) begin
            fifoMem_q[wrPtr_q] <= vect;
        end
    end

    // Toggle detection, queue pointers/occupancy and the sticky overflow flag.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            irqPrev_q <= 1'b0;
            rdPtr_q   <= '0;
            wrPtr_q   <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            irqPrev_q <= irq;
            if (fifoWrite) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (fifoPop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            if (fifoWrite && !fifoPop) begin
                count_q <= count_q + (PTR_W + 1)'(1);
            end else if (!fifoWrite && fifoPop) begin
                count_q <= count_q - (PTR_W + 1)'(1);
            end
            if (fifoDrop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Interrupt enable: accept beats DI, DI beats EI.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            iff1_q <= 1'b0;
        end else if (accept) begin
            iff1_q <= 1'b0;
        end else if (di) begin
            iff1_q <= 1'b0;
        end else if (ei) begin
            iff1_q <= 1'b1;
        end
    end

    // Entry sequence; outputs are registered so each state's values appear in that state.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            vecR_q    <= 4'd0;
            vecNmi_q  <= 1'b0;
            memWe_q   <= 1'b0;
            memAddr_q <= 16'd0;
            memOut_q  <= 8'd0;
            pcLoad_q  <= 1'b0;
            newPc_q   <= 16'd0;
            spLoad_q  <= 1'b0;
            newSp_q   <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q   <= PUSH_HI;
                        vecNmi_q  <= nmiAccept;
                        if (!nmiAccept) begin
                            vecR_q <= fifoHead;
                        end
                        memWe_q   <= 1'b1;
                        memAddr_q <= spMinus1;
                        memOut_q  <= pc[15:8];
                    end
                end
                PUSH_HI: begin
                    if (mem_ready) begin
                        state_q   <= PUSH_LO;
                        memAddr_q <= spMinus2;
                        memOut_q  <= pc[7:0];
                    end
                end
                PUSH_LO: begin
                    if (mem_ready) begin
                        state_q   <= JUMP;
                        memWe_q   <= 1'b0;
                        memAddr_q <= 16'd0;
                        memOut_q  <= 8'd0;
                        pcLoad_q  <= 1'b1;
                        spLoad_q  <= 1'b1;
                        newPc_q   <= vecNmi_q ? NMI_VECTOR : {9'b0, vecR_q, 3'b000};
                        newSp_q   <= spMinus2;
                    end
                end
                JUMP: begin
                    state_q  <= IDLE;
                    pcLoad_q <= 1'b0;
                    spLoad_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign iff1     = iff1_q;
    assign take     = accept;
    assign busy     = (state_q != IDLE);
    assign mem_we   = memWe_q;
    assign mem_addr = memAddr_q;
    assign mem_out  = memOut_q;
    assign pc_load  = pcLoad_q;
    assign new_pc   = newPc_q;
    assign sp_load  = spLoad_q;
    assign new_sp   = newSp_q;
    assign ovf      = ovf_q;

endmodule
